// File: rtl/id_decode_queue.sv
// Instruction queue and MIPS field decoder between fetch and register-read.
// Define ID_BRANCH_TARGET_EN to build the jump/branch target adders; otherwise both target ports read 0.
module id_decode_queue #(
  parameter int DEPTH     = 2,
  parameter int IMM_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [15:0]              immediate,
  output logic [25:0]              address,
  output logic [IMM_WIDTH-1:0]     imm_ext,
  output logic [1:0]               instr_type,
  output logic [31:0]              out_pc,
  output logic [31:0]              jump_target,
  output logic [31:0]              branch_target,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    TYPE_R = 2'd0,
    TYPE_I = 2'd1,
    TYPE_J = 2'd2
  } instr_type_e;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [31:0]   head_instr, head_pc;
  instr_type_e   type_d;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; out_valid gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  assign head_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign head_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'd0;

  assign opcode    = head_instr[31:26];
  assign rs        = head_instr[25:21];
  assign rt        = head_instr[20:16];
  assign rd        = head_instr[15:11];
  assign shamt     = head_instr[10:6];
  assign funct     = head_instr[5:0];
  assign immediate = head_instr[15:0];
  assign address   = head_instr[25:0];
  assign out_pc    = head_pc;

  // Logical immediates (ANDI/ORI/XORI) zero-extend; everything else sign-extends.
  always_comb begin
    if (opcode inside {6'h0C, 6'h0D, 6'h0E}) imm_ext = IMM_WIDTH'(immediate);
    else                                     imm_ext = IMM_WIDTH'($signed(immediate));
  end

  always_comb begin
    type_d = TYPE_I;
    if (opcode == 6'h00)                         type_d = TYPE_R;
    else if (opcode inside {6'h02, 6'h03})       type_d = TYPE_J;
  end
  assign instr_type = type_d;

`ifdef ID_BRANCH_TARGET_EN
  logic [31:0] pc4;
  assign pc4           = head_pc + 32'd4;
  assign jump_target   = out_valid ? {pc4[31:28], address, 2'b00} : 32'd0;
  assign branch_target = out_valid ? pc4 + {{14{immediate[15]}}, immediate, 2'b00} : 32'd0;
`else
  assign jump_target   = 32'd0;
  assign branch_target = 32'd0;
`endif

endmodule
